// File: rtl/sequence_store_pkg.sv
// rtl/sequence_store_pkg.sv - shared constants, colour type and LFSR step helper for the sequence store
package sequence_store_pkg;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    localparam int          COLOUR_WIDTH      = 4;

    typedef logic [COLOUR_WIDTH-1:0] colour_t;

    // Galois right-shift step; the tap mask folds in whenever a one falls out of bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR with seed load, step enable and next-value colour select
module lfsr16
    import sequence_store_pkg::*;
#(
    parameter int SEL_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [15:0]          seed,
    input  logic                 step,
    output logic [SEL_WIDTH-1:0] colour_sel
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_next;

    assign lfsr_next  = lfsr_step(lfsr_q);
    assign colour_sel = lfsr_next[SEL_WIDTH-1:0];

    // An all-zero state would lock the LFSR, so a zero seed falls back to the default.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            lfsr_q <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
        end else if (step) begin
            lfsr_q <= lfsr_next;
        end
    end

endmodule

// File: rtl/sequence_store.sv
// rtl/sequence_store.sv - LFSR-driven colour generator and sequence RAM for the Genius game controller
module sequence_store
    import sequence_store_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32,
    parameter int LFSR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_seed,
    input  logic                  mem_wr,
    input  logic                  mem_rd,
    input  logic                  mux_addr,
    input  logic [ADDR_WIDTH-1:0] sequence_index,
    input  logic [ADDR_WIDTH-1:0] match_index,
    input  logic                  no_repeat,
    input  logic                  test_seed_en,
    input  logic [LFSR_WIDTH-1:0] test_seed,
    output logic [DATA_WIDTH-1:0] sequence_item,
    output logic                  item_valid,
    output logic [ADDR_WIDTH:0]   seq_len,
    output logic                  full,
    output logic                  overflow
);

    localparam int SEL_WIDTH = $clog2(DATA_WIDTH);
    localparam int LEN_WIDTH = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [LFSR_WIDTH-1:0] entropy_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] prev_colour_q;
    logic                  overflow_q;

    logic [SEL_WIDTH-1:0]  colour_sel;
    logic [DATA_WIDTH-1:0] colour_raw;
    logic [DATA_WIDTH-1:0] colour;
    logic [LEN_WIDTH-1:0]  wr_len;
    logic                  wr_in_range;
    logic                  wr_accept;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_hit;

    lfsr16 #(
        .SEL_WIDTH (SEL_WIDTH)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (load_seed),
        .seed       (test_seed_en ? test_seed : entropy_q),
        .step       (wr_accept),
        .colour_sel (colour_sel)
    );

    // The colour comes from the value the LFSR is about to step to, not the current one.
    always_comb begin
        colour_raw = DATA_WIDTH'(1) << colour_sel;
        colour     = colour_raw;
        if (no_repeat && (colour_raw == prev_colour_q)) begin
            colour = {colour_raw[DATA_WIDTH-2:0], colour_raw[DATA_WIDTH-1]};
        end
    end

    assign wr_len      = {1'b0, sequence_index} + LEN_WIDTH'(1);
    assign wr_in_range = {1'b0, sequence_index} < LEN_WIDTH'(DEPTH);
    assign wr_accept   = !rst && !load_seed && mem_wr && wr_in_range;

    assign rd_addr = mux_addr ? match_index : sequence_index;
    assign rd_hit  = {1'b0, rd_addr} < len_q;

    assign seq_len  = len_q;
    assign full     = (len_q == LEN_WIDTH'(DEPTH));
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            ram[sequence_index] <= colour;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entropy_q     <= '0;
            len_q         <= '0;
            prev_colour_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            entropy_q <= entropy_q + LFSR_WIDTH'(1);
            if (load_seed) begin
                len_q         <= '0;
                prev_colour_q <= '0;
                overflow_q    <= 1'b0;
            end else if (mem_wr) begin
                if (wr_in_range) begin
                    prev_colour_q <= colour;
                    if (wr_len > len_q) begin
                        len_q <= wr_len;
                    end
                end else begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    // Reads see the pre-write RAM and length, giving read-before-write on a shared address.
    always_ff @(posedge clk) begin
        if (rst) begin
            sequence_item <= '0;
            item_valid    <= 1'b0;
        end else begin
            item_valid <= mem_rd;
            if (mem_rd) begin
                sequence_item <= rd_hit ? ram[rd_addr] : '0;
            end
        end
    end

endmodule
